// File: rtl/arb_seq_pkg.sv
// Shared types and helpers for the sequencing arbiter.
package arb_seq_pkg;

    // Controller states: idle, grant latency, grant held, forced idle gap.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_GRANT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Arbitration policy selected by the mode input.
    typedef enum logic {
        FIXED = 1'b0,
        RR    = 1'b1
    } mode_e;

    // Largest of three non-negative integers.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Width needed for a counter that must hold the largest of the three
    // timing parameters without wrapping.
    function automatic int cnt_width(input int dly, input int hold, input int gap);
        int w;
        w = $clog2(max3(dly, hold, gap) + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner picker: first set request searching upward from a
// start pointer, wrapping around. Fixed priority is the pointer forced to 0.
module arb_rr_pick
    import arb_seq_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    input  logic                     mode,
    output logic [$clog2(N_REQ)-1:0] idx,
    output logic                     valid
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] eff_ptr;
    logic [IW:0]   sum;
    logic [IW-1:0] pos;

    // Scan all requesters once, starting at the effective pointer; the first
    // hit wins and later hits are ignored.
    always_comb begin
        eff_ptr = (mode_e'(mode) == RR) ? ptr : '0;
        idx     = '0;
        valid   = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int off = 0; off < N_REQ; off++) begin
            sum = {1'b0, eff_ptr} + (IW+1)'(off);
            if (sum >= (IW+1)'(N_REQ)) begin
                sum = sum - (IW+1)'(N_REQ);
            end
            pos = sum[IW-1:0];
            if (!valid && req[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/arb_seq_ctrl.sv
// Sequencing arbiter: picks one requester, waits a programmable latency,
// grants for at most MAX_HOLD cycles, then forces GAP idle cycles before the
// next arbitration.
//
// Handshake: a requester holds req high to ask for the resource and must keep
// it high through the latency and the grant; dropping req at any edge before
// or during the grant gives the resource back (gnt falls one edge later).
// gnt is registered, one-hot or zero, and only ever high in ST_GRANT.
module arb_seq_ctrl
    import arb_seq_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int GNT_DELAY = 4,
    parameter int MAX_HOLD  = 8,
    parameter int GAP       = 1
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic                     timeout,
    output logic [1:0]               dbg_state
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = cnt_width(GNT_DELAY, MAX_HOLD, GAP);

    // Last-winner reset value gives requester 0 first round-robin priority.
    localparam logic [IW-1:0] LAST_RST  = IW'(N_REQ - 1);
    localparam logic [IW-1:0] IDX_ONE   = IW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    // WAIT/GAP count down to zero, so they are loaded with length minus one.
    localparam logic [CW-1:0] DLY_LOAD  = CW'(GNT_DELAY - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] HOLD_MAX  = CW'(MAX_HOLD);

    state_e          state, state_n;
    logic [IW-1:0]   winner, winner_n;
    logic [IW-1:0]   last_winner, last_n;
    logic [CW-1:0]   dly_cnt, dly_n;
    logic [CW-1:0]   hold_cnt, hold_n;
    logic [N_REQ-1:0] gnt_n;
    logic            timeout_n;
    logic            go_rel;

    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    // Round-robin search starts just after the most recent granted index.
    always_comb begin
        rr_ptr = (last_winner == LAST_RST) ? '0 : last_winner + IDX_ONE;
    end

    arb_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .mode  (mode),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Next-state, counter and output decode; every target defaults to hold.
    always_comb begin
        state_n   = state;
        winner_n  = winner;
        last_n    = last_winner;
        dly_n     = dly_cnt;
        hold_n    = hold_cnt;
        gnt_n     = gnt;
        timeout_n = 1'b0;
        go_rel    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    winner_n = pick_idx;
                    dly_n    = DLY_LOAD;
                    state_n  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req[winner]) begin
                    go_rel = 1'b1;
                end else if (dly_cnt == '0) begin
                    gnt_n         = '0;
                    gnt_n[winner] = 1'b1;
                    hold_n        = CNT_ONE;
                    last_n        = winner;
                    state_n       = ST_GRANT;
                end else begin
                    dly_n = dly_cnt - CNT_ONE;
                end
            end
            ST_GRANT: begin
                if (!req[winner]) begin
                    go_rel = 1'b1;
                end else if (hold_cnt == HOLD_MAX) begin
                    timeout_n = 1'b1;
                    go_rel    = 1'b1;
                end else begin
                    hold_n = hold_cnt + CNT_ONE;
                end
            end
            ST_GAP: begin
                if (dly_cnt == '0) begin
                    state_n  = ST_IDLE;
                    winner_n = '0;
                end else begin
                    dly_n = dly_cnt - CNT_ONE;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                winner_n = '0;
                gnt_n    = '0;
            end
        endcase

        // Common exit for abort, release and timeout: drop the grant and
        // either sit out the gap or return straight to idle.
        if (go_rel) begin
            gnt_n = '0;
            if (GAP == 0) begin
                state_n  = ST_IDLE;
                winner_n = '0;
            end else begin
                state_n = ST_GAP;
                dly_n   = GAP_LOAD;
            end
        end
    end

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= ST_IDLE;
            winner      <= '0;
            last_winner <= LAST_RST;
            dly_cnt     <= '0;
            hold_cnt    <= '0;
            gnt         <= '0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            winner      <= winner_n;
            last_winner <= last_n;
            dly_cnt     <= dly_n;
            hold_cnt    <= hold_n;
            gnt         <= gnt_n;
            timeout     <= timeout_n;
        end
    end

    assign gnt_id    = winner;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_arb_seq_ctrl.sv
// Directed bench for arb_seq_ctrl with default parameters. Expected grant
// rise/fall and timeout events are queued with their edge numbers; a monitor
// on the falling clock edge pops and compares whenever the DUT shows one.
module tb_arb_seq_ctrl;

    localparam int N = 4;
    localparam int W = 24;   // {type[1:0], edge[15:0], gnt[3:0], id[1:0]}

    localparam int EV_RISE = 1;
    localparam int EV_FALL = 2;
    localparam int EV_TO   = 3;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic         mode  = 1'b0;
    logic [N-1:0] req   = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;
    logic [1:0]   dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int base = 0;
    logic         mon_on = 1'b0;
    logic [N-1:0] prev_gnt = '0;
    logic [W-1:0] exp_q[$];

    arb_seq_ctrl #(
        .N_REQ     (4),
        .GNT_DELAY (4),
        .MAX_HOLD  (8),
        .GAP       (1)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .mode      (mode),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Clock and edge counter: edge_n seen at a negedge is the number of
    // rising edges so far, so "after edge k" is observed with edge_n == k.
    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic push_ev(input int t, input int e, input logic [N-1:0] g, input int id);
        logic [W-1:0] v;
        v = {t[1:0], e[15:0], g, id[1:0]};
        exp_q.push_back(v);
    endtask

    task automatic check_event(input logic [W-1:0] act);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got %h with empty queue (edge %0d)", act, edge_n);
        end else begin
            e = exp_q.pop_front();
            check("event", {8'h0, act}, {8'h0, e});
        end
    endtask

    // Monitor: per-cycle one-hot/busy sanity plus event scoreboard.
    always @(negedge clock) begin
        if (mon_on) begin
            check("gnt_onehot_busy", {31'b0, ($countones(gnt) <= 1) && ((gnt == '0) || busy)}, 32'd1);
            if (gnt != '0 && gnt != prev_gnt)
                check_event({2'(EV_RISE), edge_n[15:0], gnt, gnt_id});
            if (gnt == '0 && prev_gnt != '0)
                check_event({2'(EV_FALL), edge_n[15:0], 4'b0, 2'b0});
            if (timeout)
                check_event({2'(EV_TO), edge_n[15:0], 4'b0, 2'b0});
            prev_gnt = gnt;
        end
    end

    // Return at the negedge where edge_n == k; inputs set here are sampled
    // at rising edge k+1.
    task automatic wait_neg(input int k);
        while (edge_n < k) @(negedge clock);
    endtask

    // Two reset edges; afterwards base is the current edge, so the first
    // non-reset edge is base+1.
    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        mode = 1'b0;
        @(negedge clock);
        @(negedge clock);
        rst  = 1'b0;
        base = edge_n;
    endtask

    initial begin
        int b;
        @(negedge clock);
        do_reset();
        check("rst_gnt", {28'b0, gnt}, 32'd0);
        check("rst_gnt_id", {30'b0, gnt_id}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        check("rst_state", {30'b0, dbg_state}, 32'd0);
        prev_gnt = gnt;
        mon_on   = 1'b1;

        // Fixed priority: 1010 at edge 10, release 1 at 17, 3 wins at 19.
        b = base;
        push_ev(EV_RISE, b+14, 4'b0010, 1);
        push_ev(EV_FALL, b+17, 4'b0000, 0);
        push_ev(EV_RISE, b+23, 4'b1000, 3);
        push_ev(EV_FALL, b+26, 4'b0000, 0);
        wait_neg(b+9);  mode = 1'b0; req = 4'b1010;
        wait_neg(b+10);
        check("s1_busy_arb", {31'b0, busy}, 32'd1);
        check("s1_id_arb", {30'b0, gnt_id}, 32'd1);
        wait_neg(b+16); req = 4'b1000;
        wait_neg(b+20);
        check("s1_id_wait3", {30'b0, gnt_id}, 32'd3);
        wait_neg(b+25); req = 4'b0000;
        wait_neg(b+27);
        check("s1_busy_idle", {31'b0, busy}, 32'd0);
        check("s1_id_idle", {30'b0, gnt_id}, 32'd0);
        wait_neg(b+30);

        // Round robin, all requesting: rotation 0,1,2,3,0 with timeouts.
        do_reset();
        b = base;
        for (int k = 0; k < 5; k++) begin
            push_ev(EV_RISE, b+5+14*k, 4'(1 << (k % 4)), k % 4);
            push_ev(EV_FALL, b+13+14*k, 4'b0000, 0);
            push_ev(EV_TO,   b+13+14*k, 4'b0000, 0);
        end
        mode = 1'b1; req = 4'b1111;
        wait_neg(b+69); req = 4'b0000;
        wait_neg(b+73);

        // Single requester held 30 cycles: timeout then re-grant.
        do_reset();
        b = base;
        push_ev(EV_RISE, b+5,  4'b0100, 2);
        push_ev(EV_FALL, b+13, 4'b0000, 0);
        push_ev(EV_TO,   b+13, 4'b0000, 0);
        push_ev(EV_RISE, b+19, 4'b0100, 2);
        push_ev(EV_FALL, b+27, 4'b0000, 0);
        push_ev(EV_TO,   b+27, 4'b0000, 0);
        mode = 1'b0; req = 4'b0100;
        wait_neg(b+30);
        check("s3_pending_busy", {31'b0, busy}, 32'd1);
        check("s3_pending_id", {30'b0, gnt_id}, 32'd2);
        req = 4'b0000;
        wait_neg(b+33);
        check("s3_busy_idle", {31'b0, busy}, 32'd0);

        // Abort during grant latency: no grant, idle after edge 13.
        do_reset();
        b = base;
        wait_neg(b+9);  mode = 1'b0; req = 4'b0001;
        wait_neg(b+10);
        check("s4_busy_arb", {31'b0, busy}, 32'd1);
        wait_neg(b+11); req = 4'b0000;
        wait_neg(b+12);
        check("s4_busy_gap", {31'b0, busy}, 32'd1);
        check("s4_state_gap", {30'b0, dbg_state}, 32'd3);
        wait_neg(b+13);
        check("s4_busy_idle", {31'b0, busy}, 32'd0);
        wait_neg(b+16);

        // Reset while requester 2 holds the grant, then RR from scratch.
        do_reset();
        b = base;
        push_ev(EV_RISE, b+5,  4'b0100, 2);
        push_ev(EV_FALL, b+7,  4'b0000, 0);
        push_ev(EV_RISE, b+12, 4'b0001, 0);
        push_ev(EV_FALL, b+13, 4'b0000, 0);
        mode = 1'b0; req = 4'b0100;
        wait_neg(b+6);
        check("s5_gnt_before_rst", {28'b0, gnt}, 32'h4);
        rst = 1'b1; req = 4'b0011; mode = 1'b1;
        wait_neg(b+7);
        check("s5_rst_outputs", {24'b0, gnt, gnt_id, busy, timeout}, 32'd0);
        check("s5_rst_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        wait_neg(b+12); req = 4'b0000;
        wait_neg(b+16);

        // Idle: nothing requested for 50 cycles.
        do_reset();
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("s6_idle", {29'b0, (gnt != '0), busy, timeout}, 32'd0);
        end

        repeat (4) @(negedge clock);
        while (exp_q.size() > 0) begin
            logic [W-1:0] m;
            m = exp_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_event: expected %h never observed", m);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
